// File: rtl/keypad_scan_pkg.sv
// Shared keypad definitions: key codes, matrix dimensions and the
// (row, col) to key-code map used by the scanner.
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 3;
   localparam int NUM_KEYS = 12;

   typedef enum logic [3:0] {
      KEY_0    = 4'd0,
      KEY_1    = 4'd1,
      KEY_2    = 4'd2,
      KEY_3    = 4'd3,
      KEY_4    = 4'd4,
      KEY_5    = 4'd5,
      KEY_6    = 4'd6,
      KEY_7    = 4'd7,
      KEY_8    = 4'd8,
      KEY_9    = 4'd9,
      KEY_STAR = 4'd10,
      KEY_HASH = 4'd11
   } key_code_e;

   // Rows 0..2 are the digit block 1..9; row 3 is '*', '0', '#'.
   function automatic logic [3:0] key_at(input int row, input int col);
      logic [3:0] code;
      if (row < 3) begin
         code = 4'(row * NUM_COLS + col + 1);
      end else begin
         case (col)
            0:       code = KEY_STAR;
            1:       code = KEY_0;
            default: code = KEY_HASH;
         endcase
      end
      return code;
   endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad-side and event-side signals of the scanner, bundled for the top port.
interface keypad_scan_if;
   import keypad_pkg::*;

   // key_valid is a one-cycle event that qualifies key_code; there is no
   // ready: the consumer must take it in that cycle. key_code holds between events.
   logic [NUM_ROWS-1:0] rows_n;
   logic [NUM_COLS-1:0] col_out;
   logic [NUM_KEYS-1:0] keys;
   logic                key0;
   logic                key8;
   logic                key_star;
   logic                key_valid;
   logic [3:0]          key_code;
   logic [1:0]          col_idx;

   modport slave (
      input  rows_n,
      output col_out, keys, key0, key8, key_star, key_valid, key_code, col_idx
   );

   modport master (
      output rows_n,
      input  col_out, keys, key0, key8, key_star, key_valid, key_code, col_idx
   );

endinterface

// File: rtl/keypad_scan_debounce.sv
// Per-key debounce cell: the stable level flips only after DEBOUNCE_SCANS
// consecutive evaluations that disagree with it.
module key_debounce #(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic eval,
   input  logic raw,
   output logic stable,
   output logic rise
);

   logic [2:0] r_count;
   logic       r_stable;
   logic       w_differ;
   logic       w_flip;

   assign w_differ = (raw != r_stable);
   // Compare one bit wider so the count never has to hold DEBOUNCE_SCANS itself.
   assign w_flip   = eval && w_differ && (({1'b0, r_count} + 4'd1) == 4'(DEBOUNCE_SCANS));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count  <= 3'd0;
         r_stable <= 1'b0;
      end else if (eval) begin
         if (w_flip) begin
            r_stable <= ~r_stable;
            r_count  <= 3'd0;
         end else if (w_differ) begin
            r_count  <= r_count + 3'd1;
         end else begin
            r_count  <= 3'd0;
         end
      end
   end

   assign stable = r_stable;
   assign rise   = w_flip && !r_stable;

endmodule

// File: rtl/keypad_scan.sv
// 4x3 matrix keypad scanner: column sequencer, row synchronizer, raw press
// image, 12 debounce cells and a lowest-code new-press reporter.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter logic [15:0] SCAN_PERIOD    = 16'd500,
   parameter int          DEBOUNCE_SCANS = 4
) (
   input  logic          clk,
   input  logic          rst,
   keypad_scan_if.slave  kp
);

   logic [NUM_ROWS-1:0] r_sync1;
   logic [NUM_ROWS-1:0] r_sync2;
   logic [15:0]         r_dwell;
   logic [1:0]          r_col_idx;
   logic [NUM_COLS-1:0] r_col_out;
   logic [NUM_KEYS-1:0] r_raw;
   logic                r_eval;
   logic                r_key_valid;
   logic [3:0]          r_key_code;

   logic                w_tc;
   logic [1:0]          w_col_next;
   logic [NUM_KEYS-1:0] w_raw_next;
   logic [NUM_KEYS-1:0] w_stable;
   logic [NUM_KEYS-1:0] w_rise;
   logic [3:0]          w_low_code;
   logic                w_any_rise;

   assign w_tc       = (r_dwell == SCAN_PERIOD - 16'd1);
   assign w_col_next = (r_col_idx == 2'd2) ? 2'd0 : r_col_idx + 2'd1;
   assign w_any_rise = |w_rise;

   // Capture the driven column's rows at the end of its dwell; row low = pressed.
   always_comb begin
      w_raw_next = r_raw;
      if (w_tc) begin
         for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
               if (r_col_idx == 2'(c)) begin
                  w_raw_next[key_at(r, c)] = ~r_sync2[r];
               end
            end
         end
      end
   end

   always_comb begin
      w_low_code = 4'd0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (w_rise[i]) begin
            w_low_code = 4'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1     <= 4'b1111;
         r_sync2     <= 4'b1111;
         r_dwell     <= 16'd0;
         r_col_idx   <= 2'd0;
         r_col_out   <= 3'b110;
         r_raw       <= '0;
         r_eval      <= 1'b0;
         r_key_valid <= 1'b0;
         r_key_code  <= 4'd0;
      end else begin
         r_sync1     <= kp.rows_n;
         r_sync2     <= r_sync1;
         r_dwell     <= w_tc ? 16'd0 : r_dwell + 16'd1;
         if (w_tc) begin
            r_col_idx <= w_col_next;
            r_col_out <= ~(3'b001 << w_col_next);
         end
         r_raw       <= w_raw_next;
         // Round ends with column 2's capture; debounce runs on the next cycle.
         r_eval      <= w_tc && (r_col_idx == 2'd2);
         r_key_valid <= w_any_rise;
         if (w_any_rise) begin
            r_key_code <= w_low_code;
         end
      end
   end

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
      ) u_debounce (
         .clk    (clk),
         .rst    (rst),
         .eval   (r_eval),
         .raw    (r_raw[g]),
         .stable (w_stable[g]),
         .rise   (w_rise[g])
      );
   end

   assign kp.col_out   = r_col_out;
   assign kp.col_idx   = r_col_idx;
   assign kp.keys      = w_stable;
   assign kp.key0      = w_stable[KEY_0];
   assign kp.key8      = w_stable[KEY_8];
   assign kp.key_star  = w_stable[KEY_STAR];
   assign kp.key_valid = r_key_valid;
   assign kp.key_code  = r_key_code;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with SCAN_PERIOD=4, DEBOUNCE_SCANS=3 (12-cycle rounds):
// directed round table, hand sequences for reset/sequencing, random rounds vs model.
module tb_keypad_scan;

   localparam int N_DB   = 3;
   localparam int ROUND  = 12;

   typedef struct {
      logic [11:0] pressed;
      logic [11:0] keys;
      logic        valid;
      logic [3:0]  code;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [11:0] pressed;
   logic [3:0]  rows_drv;
   int          n_vec;
   int          n_err;
   vec_t        tbl[$];

   // Reference model state
   logic [11:0] hist[$];
   logic [11:0] m_keys;
   logic [3:0]  m_code;
   logic        m_valid;

   keypad_scan_if kp();

   keypad_scan #(
      .SCAN_PERIOD    (16'd4),
      .DEBOUNCE_SCANS (N_DB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int tb_key(input int r, input int c);
      int map [4][3];
      map = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};
      return map[r][c];
   endfunction

   // Physical keypad: a pressed key shorts its row to the low-driven column.
   always_comb begin
      rows_drv = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (!kp.col_out[c] && pressed[tb_key(r, c)]) rows_drv[r] = 1'b0;
         end
      end
   end
   assign kp.rows_n = rows_drv;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Enter at negedge in dwell 1 of column 0; leave at the negedge right after
   // this round's evaluation result becomes visible.
   task automatic run_round(input logic [11:0] p, output int pulses);
      pressed = p;
      pulses  = 0;
      for (int i = 0; i < ROUND; i++) begin
         @(negedge clk);
         if (kp.key_valid) pulses++;
      end
   endtask

   task automatic reset_align();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic model_reset();
      hist.delete();
      m_keys = '0;
      m_code = 4'd0;
   endtask

   // A key's level flips once its last N_DB round images all disagree with it.
   task automatic model_round(input logic [11:0] p);
      logic [11:0] rises;
      logic        all_diff;
      int          sz;
      hist.push_back(p);
      sz    = hist.size();
      rises = '0;
      for (int k = 0; k < 12; k++) begin
         if (sz >= N_DB) begin
            all_diff = 1'b1;
            for (int j = 1; j <= N_DB; j++) begin
               if (hist[sz - j][k] == m_keys[k]) all_diff = 1'b0;
            end
            if (all_diff) begin
               m_keys[k] = ~m_keys[k];
               if (m_keys[k]) rises[k] = 1'b1;
            end
         end
      end
      m_valid = |rises;
      for (int k = 11; k >= 0; k--) begin
         if (rises[k]) m_code = 4'(k);
      end
   endtask

   task automatic add_vec(input logic [11:0] p, input logic [11:0] k, input logic v,
                          input logic [3:0] c);
      vec_t e;
      e.pressed = p;
      e.keys    = k;
      e.valid   = v;
      e.code    = c;
      tbl.push_back(e);
   endtask

   task automatic check_keys(input string tag, input logic [11:0] k, input int pulses,
                             input int exp_pulses, input logic [3:0] c);
      check({tag, " keys"}, 32'(kp.keys), 32'(k));
      check({tag, " pulses"}, 32'(pulses), 32'(exp_pulses));
      check({tag, " code"}, 32'(kp.key_code), 32'(c));
      check({tag, " alias"}, 32'({kp.key0, kp.key8, kp.key_star}), 32'({k[0], k[8], k[10]}));
   endtask

   initial begin
      logic [2:0]  colpat [3];
      logic [11:0] target;
      logic [11:0] noise;
      logic [11:0] p;
      int          pulses;

      n_vec   = 0;
      n_err   = 0;
      rst     = 1'b1;
      pressed = '0;
      colpat  = '{3'b110, 3'b101, 3'b011};

      // Reset values and column sequencing
      repeat (3) @(negedge clk);
      check("rst col_out", 32'(kp.col_out), 32'(3'b110));
      check("rst keys", 32'(kp.keys), 32'd0);
      check("rst key_valid", 32'(kp.key_valid), 32'd0);
      check("rst key_code", 32'(kp.key_code), 32'd0);
      check("rst alias", 32'({kp.key0, kp.key8, kp.key_star}), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check("seq col_out", 32'(kp.col_out), 32'(colpat[(i / 4) % 3]));
         @(negedge clk);
      end

      // Directed round table
      for (int i = 0; i < 3; i++) add_vec(12'h100, (i == 2) ? 12'h100 : 12'h000, i == 2, (i == 2) ? 4'd8 : 4'd0);
      for (int i = 0; i < 3; i++) add_vec(12'h000, (i == 2) ? 12'h000 : 12'h100, 1'b0, 4'd8);
      for (int i = 0; i < 10; i++) add_vec((i % 2 == 0) ? 12'h100 : 12'h000, 12'h000, 1'b0, 4'd8);
      for (int i = 0; i < 3; i++) add_vec(12'h401, (i == 2) ? 12'h401 : 12'h000, i == 2, (i == 2) ? 4'd0 : 4'd8);
      for (int i = 0; i < 3; i++) add_vec(12'h000, (i == 2) ? 12'h000 : 12'h401, 1'b0, 4'd0);
      for (int i = 0; i < 3; i++) add_vec(12'h008, (i == 2) ? 12'h008 : 12'h000, i == 2, (i == 2) ? 4'd3 : 4'd0);
      for (int i = 0; i < 3; i++) add_vec(12'h000, (i == 2) ? 12'h000 : 12'h008, 1'b0, 4'd3);

      reset_align();
      foreach (tbl[i]) begin
         run_round(tbl[i].pressed, pulses);
         check_keys("table", tbl[i].keys, pulses, int'(tbl[i].valid), tbl[i].code);
      end

      // Reset mid-debounce: two rounds of '5', reset mid-dwell, counting restarts
      pressed = '0;
      reset_align();
      for (int i = 0; i < 2; i++) begin
         run_round(12'h020, pulses);
         check_keys("pre-reset", 12'h000, pulses, 0, 4'd0);
      end
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         run_round(12'h020, pulses);
         check_keys("post-reset", (i == 2) ? 12'h020 : 12'h000, pulses, (i == 2) ? 1 : 0,
                    (i == 2) ? 4'd5 : 4'd0);
      end

      // Random rounds against the model
      pressed = '0;
      reset_align();
      model_reset();
      target = '0;
      for (int n = 0; n < 60; n++) begin
         for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 5) == 0) target[k] = ~target[k];
         end
         noise = '0;
         if ($urandom_range(0, 2) == 0) noise[$urandom_range(0, 11)] = 1'b1;
         p = target ^ noise;
         run_round(p, pulses);
         model_round(p);
         check_keys("random", m_keys, pulses, m_valid ? 1 : 0, m_code);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
